dm_stage_pipe: RTL and testbench
================================

// Module: dm_stage_pipe
// PURPOSE
//   Parametrised MEM stage of the MIPS pipeline: owns an inferred synchronous data RAM,
//   accepts the EX-stage ALU result/store data and returns the WB operand one cycle later.
//   Adds byte/word access with sign/zero extension, a valid/stall handshake,
//   misalignment detection and a saturating error counter.
//   Sits between the execute block and the write-back mux.
// PARAMETERS
//   DATA_W  16  datapath width; multiple of 8, >= 16
//   ADDR_W  8   word-address bits; RAM depth = 2**ADDR_W words
//   CNT_W   8   width of err_count
//   (local) LB = log2(DATA_W/8) byte-select bits; lane 0 = bits [7:0] (little-endian)
// PORTS
//   clk            in   1       rising-edge clock
//   reset          in   1       synchronous, active-high reset
//   valid_ex       in   1       EX stage presents a valid instruction
//   stall_dm       in   1       hold MEM stage; no state changes
//   ans_ex         in   DATA_W  ALU result / byte address
//   dm_data        in   DATA_W  store data (byte store uses bits [7:0])
//   mem_en_ex      in   1       instruction accesses memory
//   mem_rw_ex      in   1       1 = store, 0 = load
//   mem_size_ex    in   1       0 = byte, 1 = full word
//   mem_sign_ex    in   1       byte load: 1 = sign-extend, 0 = zero-extend
//   mem_mux_sel_ex in   1       0 = pass ALU result, 1 = pass load data
//   valid_dm       out  1       ans_dm holds a valid result
//   ans_dm         out  DATA_W  WB operand
//   misalign_dm    out  1       result instruction was a misaligned word access
//   err_count      out  CNT_W   saturating count of misaligned accesses
// BEHAVIOUR
//   - Word index = ans_ex[ADDR_W+LB-1:LB]; lane = ans_ex[LB-1:0]; higher bits ignored (alias).
//   - Accept = valid_ex & ~stall_dm & ~reset. Latency exactly 1 cycle: accepted op at edge N
//     -> valid_dm/ans_dm/misalign_dm valid after edge N.
//   - Not accepted (valid_ex=0, stall_dm=0): valid_dm <= 0 after edge; other outputs don't-care.
//   - stall_dm=1: all output regs, RAM read register and err_count hold; no RAM write.
//   - Misaligned = mem_en_ex & mem_size_ex & (lane != 0). Misaligned store is suppressed;
//     misaligned load returns 0. misalign_dm=1, err_count += 1, saturating at all-ones.
//   - Word store: RAM[idx] <= dm_data at accept edge. Byte store: only lane bits written
//     with dm_data[7:0]; other lanes unchanged (per-lane write enable, no read-modify-write).
//   - Load: RAM read registered at accept edge; byte load extracts lane then extends per
//     mem_sign_ex; word load returns full word.
//   - ans_dm = registered mux_sel ? load_data : registered ans_ex. Store with mux_sel=1
//     returns the pre-write RAM word (read-first); stores normally use mux_sel=0.
//   - Back-to-back store then load to same address: load returns newly stored data.
//   - mem_en_ex=0: no RAM read or write; ALU result path only.
//   - Reset (priority over all): valid_dm=0, ans_dm=0, misalign_dm=0, err_count=0.
//     Store presented in the reset cycle is dropped. RAM contents are NOT cleared.
//   - Reset while stalled: reset wins; outputs cleared.
// TESTING  (DATA_W=16, ADDR_W=8, CNT_W=8)
//   1 Reset: assert reset 2 cycles with valid store -> outputs 0, RAM[0x05] unchanged.
//   2 Word store 0xBEEF @0x000A, then word load @0x000A mux_sel=1 -> next cycle
//     ans_dm=0xBEEF, valid_dm=1.
//   3 Byte store 0x80 @0x000B onto 0xBEEF; byte load @0x000B sign=1 -> 0xFF80;
//     sign=0 -> 0x0080; word load @0x000A -> 0x80EF.
//   4 Word load @0x0003 -> misalign_dm=1, ans_dm=0, err_count=1; word store @0x0003
//     0x1234 -> RAM[1] unchanged; drive 300 misaligned ops -> err_count=0xFF.
//   5 ALU op ans_ex=0x7777 mux_sel=0 with stall_dm=1 for 3 cycles -> outputs frozen;
//     release -> ans_dm=0x7777 one cycle later; no RAM write during stall.
//   6 Address alias: store 0xAAAA @0x0204 -> load @0x0004 returns 0xAAAA.

Source files
------------

// File: rtl/dm_stage_pipe.sv
// MEM stage of the MIPS pipeline: byte/word data RAM access with extension,
// valid/stall handshake, misalignment detection and a saturating error counter.
module dm_stage_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_ex,
  input  logic              stall_dm,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [DATA_W-1:0] dm_data,
  input  logic              mem_en_ex,
  input  logic              mem_rw_ex,
  input  logic              mem_size_ex,
  input  logic              mem_sign_ex,
  input  logic              mem_mux_sel_ex,
  output logic              valid_dm,
  output logic [DATA_W-1:0] ans_dm,
  output logic              misalign_dm,
  output logic [CNT_W-1:0]  err_count
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned LB    = $clog2(NB);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] ram [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic [LB-1:0]     lane;
  logic              accept;
  logic              misalign;
  logic              wr_en;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rd_word;
  logic [7:0]        rd_byte;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] result;

  // Upper address bits beyond the word index are ignored, so addresses alias.
  assign idx      = ans_ex[ADDR_W+LB-1:LB];
  assign lane     = ans_ex[LB-1:0];
  assign accept   = valid_ex & ~stall_dm & ~reset;
  assign misalign = mem_en_ex & mem_size_ex & (lane != '0);
  assign wr_en    = accept & mem_en_ex & mem_rw_ex & ~misalign;

  // Per-lane write enables; a byte store replicates its byte across lanes.
  always_comb begin
    be    = '0;
    wdata = mem_size_ex ? dm_data : {NB{dm_data[7:0]}};
    for (int b = 0; b < NB; b++) begin
      be[b] = wr_en & (mem_size_ex | (lane == LB'(b)));
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (be[b]) ram[idx][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  // Read-first: the word is sampled into ans_dm on the same edge a store updates it.
  always_comb begin
    rd_word   = ram[idx];
    rd_byte   = 8'(rd_word >> {lane, 3'b000});
    load_data = '0;
    if (mem_en_ex && !misalign) begin
      if (mem_size_ex)      load_data = rd_word;
      else if (mem_sign_ex) load_data = {{(DATA_W-8){rd_byte[7]}}, rd_byte};
      else                  load_data = {{(DATA_W-8){1'b0}}, rd_byte};
    end
    result = mem_mux_sel_ex ? load_data : ans_ex;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_dm    <= 1'b0;
      ans_dm      <= '0;
      misalign_dm <= 1'b0;
      err_count   <= '0;
    end else if (!stall_dm) begin
      valid_dm <= valid_ex;
      if (accept) begin
        ans_dm      <= result;
        misalign_dm <= misalign;
        if (misalign && err_count != {CNT_W{1'b1}}) err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dm_stage_pipe.sv
// Directed, table-driven bench for dm_stage_pipe (DATA_W=16, ADDR_W=8, CNT_W=8).
module tb_dm_stage_pipe;

  logic        clk = 1'b0;
  logic        reset, valid_ex, stall_dm;
  logic [15:0] ans_ex, dm_data;
  logic        mem_en_ex, mem_rw_ex, mem_size_ex, mem_sign_ex, mem_mux_sel_ex;
  logic        valid_dm, misalign_dm;
  logic [15:0] ans_dm;
  logic [7:0]  err_count;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  dm_stage_pipe #(.DATA_W(16), .ADDR_W(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .valid_ex(valid_ex), .stall_dm(stall_dm),
    .ans_ex(ans_ex), .dm_data(dm_data), .mem_en_ex(mem_en_ex), .mem_rw_ex(mem_rw_ex),
    .mem_size_ex(mem_size_ex), .mem_sign_ex(mem_sign_ex), .mem_mux_sel_ex(mem_mux_sel_ex),
    .valid_dm(valid_dm), .ans_dm(ans_dm), .misalign_dm(misalign_dm), .err_count(err_count)
  );

  typedef struct {
    logic        valid;
    logic [15:0] addr;
    logic [15:0] data;
    logic        en, rw, size, sign, sel;
    logic        exp_valid;
    logic [15:0] exp_ans;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic v, logic [15:0] a, logic [15:0] d, logic en, logic rw,
                              logic sz, logic sg, logic sel, logic ev, logic [15:0] ea);
    vec_t r;
    r.valid = v; r.addr = a; r.data = d; r.en = en; r.rw = rw; r.size = sz;
    r.sign = sg; r.sel = sel; r.exp_valid = ev; r.exp_ans = ea;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] d, input logic en,
                       input logic rw, input logic sz, input logic sg, input logic sel);
    valid_ex = v; ans_ex = a; dm_data = d; mem_en_ex = en; mem_rw_ex = rw;
    mem_size_ex = sz; mem_sign_ex = sg; mem_mux_sel_ex = sel;
  endtask

  // One clock edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Columns: valid, addr, data, en, rw, size, sign, sel, exp_valid, exp_ans
    vecs[0]  = mk(1, 16'h000A, 16'hBEEF, 1, 1, 1, 0, 0, 1, 16'h000A); // word store
    vecs[1]  = mk(1, 16'h000A, 16'h0000, 1, 0, 1, 0, 1, 1, 16'hBEEF); // word load
    vecs[2]  = mk(1, 16'h000B, 16'h1280, 1, 1, 0, 0, 0, 1, 16'h000B); // byte store lane 1
    vecs[3]  = mk(1, 16'h000B, 16'h0000, 1, 0, 0, 1, 1, 1, 16'hFF80); // byte load signed
    vecs[4]  = mk(1, 16'h000B, 16'h0000, 1, 0, 0, 0, 1, 1, 16'h0080); // byte load unsigned
    vecs[5]  = mk(1, 16'h000A, 16'h0000, 1, 0, 1, 0, 1, 1, 16'h80EF); // word after byte store
    vecs[6]  = mk(1, 16'h000A, 16'h0000, 1, 0, 0, 1, 1, 1, 16'hFFEF); // byte load lane 0
    vecs[7]  = mk(1, 16'h000A, 16'h5634, 1, 1, 0, 0, 0, 1, 16'h000A); // byte store lane 0
    vecs[8]  = mk(1, 16'h000A, 16'h0000, 1, 0, 1, 0, 1, 1, 16'h8034); // back-to-back load
    vecs[9]  = mk(1, 16'h0204, 16'hAAAA, 1, 1, 1, 0, 0, 1, 16'h0204); // aliased store
    vecs[10] = mk(1, 16'h0004, 16'h0000, 1, 0, 1, 0, 1, 1, 16'hAAAA); // alias load
    vecs[11] = mk(1, 16'h0004, 16'h5555, 1, 1, 1, 0, 1, 1, 16'hAAAA); // store read-first
    vecs[12] = mk(1, 16'h0004, 16'h0000, 1, 0, 1, 0, 1, 1, 16'h5555); // sees new data
    vecs[13] = mk(1, 16'h0002, 16'h4321, 1, 1, 1, 0, 0, 1, 16'h0002); // RAM[1] = 0x4321

    reset = 1'b1; stall_dm = 1'b0;
    drive(0, 16'h0, 16'h0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;

    // Reset drops a concurrent store and clears outputs.
    drive(1, 16'h000A, 16'h1111, 1, 1, 1, 0, 0);
    step();
    reset = 1'b1;
    drive(1, 16'h000A, 16'h2222, 1, 1, 1, 0, 0);
    step(); step();
    chk("rst_valid", 32'(valid_dm), 32'h0);
    chk("rst_ans", 32'(ans_dm), 32'h0);
    chk("rst_mis", 32'(misalign_dm), 32'h0);
    chk("rst_err", 32'(err_count), 32'h0);
    reset = 1'b0;
    drive(1, 16'h000A, 16'h0000, 1, 0, 1, 0, 1);
    step();
    chk("rst_ram_kept", 32'(ans_dm), 32'h1111);

    // Idle cycle deasserts valid_dm.
    drive(0, 16'h1234, 16'h0, 0, 0, 0, 0, 0);
    step();
    chk("idle_valid", 32'(valid_dm), 32'h0);

    // ALU pass-through.
    drive(1, 16'h1234, 16'h0, 0, 0, 0, 0, 0);
    step();
    chk("alu_ans", 32'(ans_dm), 32'h1234);

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].valid, vecs[i].addr, vecs[i].data, vecs[i].en, vecs[i].rw,
            vecs[i].size, vecs[i].sign, vecs[i].sel);
      step();
      chk($sformatf("vec%0d_valid", i), 32'(valid_dm), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_ans", i), 32'(ans_dm), 32'(vecs[i].exp_ans));
      chk($sformatf("vec%0d_mis", i), 32'(misalign_dm), 32'h0);
    end
    chk("tbl_err", 32'(err_count), 32'h0);

    // Misaligned word store is suppressed and counted.
    drive(1, 16'h0003, 16'h1234, 1, 1, 1, 0, 0);
    step();
    chk("mst_mis", 32'(misalign_dm), 32'h1);
    chk("mst_err", 32'(err_count), 32'h1);
    drive(1, 16'h0003, 16'h0000, 1, 0, 1, 0, 1);
    step();
    chk("mld_ans", 32'(ans_dm), 32'h0);
    chk("mld_mis", 32'(misalign_dm), 32'h1);
    chk("mld_err", 32'(err_count), 32'h2);
    drive(1, 16'h0002, 16'h0000, 1, 0, 1, 0, 1);
    step();
    chk("ram1_kept", 32'(ans_dm), 32'h4321);
    chk("ram1_mis", 32'(misalign_dm), 32'h0);
    // Byte access at an odd address is not misaligned.
    drive(1, 16'h0003, 16'h0000, 1, 0, 0, 0, 1);
    step();
    chk("odd_byte_ans", 32'(ans_dm), 32'h0043);
    chk("odd_byte_mis", 32'(misalign_dm), 32'h0);
    chk("odd_byte_err", 32'(err_count), 32'h2);

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) begin
      drive(1, 16'h0001, 16'h0000, 1, 0, 1, 0, 1);
      step();
    end
    chk("err_sat", 32'(err_count), 32'hFF);

    // Stall freezes outputs and the ALU op completes after release.
    drive(1, 16'h0002, 16'h0000, 1, 0, 1, 0, 1);
    step();
    chk("pre_stall_ans", 32'(ans_dm), 32'h4321);
    stall_dm = 1'b1;
    drive(1, 16'h7777, 16'h0000, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d_ans", i), 32'(ans_dm), 32'h4321);
      chk($sformatf("stall%0d_valid", i), 32'(valid_dm), 32'h1);
    end
    stall_dm = 1'b0;
    step();
    chk("release_ans", 32'(ans_dm), 32'h7777);
    chk("release_err", 32'(err_count), 32'hFF);

    // A stalled store must not write RAM.
    stall_dm = 1'b1;
    drive(1, 16'h0002, 16'h9999, 1, 1, 1, 0, 0);
    step(); step();
    chk("stall_st_ans", 32'(ans_dm), 32'h7777);
    stall_dm = 1'b0;
    drive(0, 16'h0002, 16'h9999, 1, 1, 1, 0, 0);
    step();
    chk("drop_valid", 32'(valid_dm), 32'h0);
    drive(1, 16'h0002, 16'h0000, 1, 0, 1, 0, 1);
    step();
    chk("no_stall_write", 32'(ans_dm), 32'h4321);

    // Reset wins over stall.
    stall_dm = 1'b1;
    reset = 1'b1;
    step();
    chk("rst_stall_valid", 32'(valid_dm), 32'h0);
    chk("rst_stall_ans", 32'(ans_dm), 32'h0);
    chk("rst_stall_err", 32'(err_count), 32'h0);
    reset = 1'b0;
    stall_dm = 1'b0;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
